// File: rtl/regbank_arbiter.sv
// regbank_arbiter: two-requester arbiter/sequencer in front of the 8x8
// single-write-port register bank. One op is in flight at a time:
// IDLE (grant) -> ACCESS (drive bank, capture reads) -> RESP (pulse rsp_valid).
// Build option: define ARB_RR_EN for round-robin tie-breaking; left undefined,
// requester A has fixed priority over B.
//
// Handshake: x_ready is a one-cycle pulse, only in IDLE, combinational on
// x_valid. An op transfers on the clock edge where x_valid && x_ready. The
// requester holds x_valid and its op fields stable until then. x_rsp_valid
// pulses for one cycle, two cycles after x_ready. rsp_data1/2 and rsp_err are
// valid with that pulse and hold until the next capture.
module regbank_arbiter #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 3,
  parameter bit ZERO_PROTECT = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr1,
  input  logic [ADDR_W-1:0] a_addr2,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_rsp_valid,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr1,
  input  logic [ADDR_W-1:0] b_addr2,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] rsp_data1,
  output logic [DATA_W-1:0] rsp_data2,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] rb_add1,
  output logic [ADDR_W-1:0] rb_add2,
  output logic [DATA_W-1:0] rb_in,
  output logic              rb_we,
  input  logic [DATA_W-1:0] rb_out1,
  input  logic [DATA_W-1:0] rb_out2,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_owner_b;
  logic              r_op_we;
  logic [ADDR_W-1:0] r_op_addr1;
  logic [ADDR_W-1:0] r_op_addr2;
  logic [DATA_W-1:0] r_op_wdata;
  logic [DATA_W-1:0] r_rsp_data1;
  logic [DATA_W-1:0] r_rsp_data2;
  logic              r_rsp_err;
  logic              w_grant_a;
  logic              w_grant_b;
  logic              w_grant;
  logic              w_addr0_drop;

`ifdef ARB_RR_EN
  logic r_prefer_b;

  // Round-robin winner select: on a tie, the requester not granted last wins
  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (r_state == ST_IDLE) begin
      w_grant_a = a_valid & (~b_valid | ~r_prefer_b);
      w_grant_b = b_valid & ~w_grant_a;
    end
  end

  // Pointer moves to the other requester on every grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prefer_b <= 1'b0;
    end else if (w_grant_a) begin
      r_prefer_b <= 1'b1;
    end else if (w_grant_b) begin
      r_prefer_b <= 1'b0;
    end
  end
`else
  // Fixed-priority winner select: A always wins a tie, B can starve
  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (r_state == ST_IDLE) begin
      w_grant_a = a_valid;
      w_grant_b = b_valid & ~a_valid;
    end
  end
`endif

  assign w_grant      = w_grant_a | w_grant_b;
  // r0 is a constant in the bank, so writes to it are dropped and reported
  assign w_addr0_drop = ZERO_PROTECT & r_op_we & (r_op_addr1 == '0);

  // State register; reset mid-op returns to IDLE and drops the op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-state outputs; bank pins idle at zero outside ACCESS
  always_comb begin
    w_state_nxt = r_state;
    a_ready     = 1'b0;
    b_ready     = 1'b0;
    a_rsp_valid = 1'b0;
    b_rsp_valid = 1'b0;
    rb_add1     = '0;
    rb_add2     = '0;
    rb_in       = '0;
    rb_we       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        a_ready = w_grant_a;
        b_ready = w_grant_b;
        if (w_grant) begin
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        rb_add1     = r_op_addr1;
        rb_add2     = r_op_addr2;
        rb_in       = r_op_wdata;
        rb_we       = r_op_we & ~w_addr0_drop;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        a_rsp_valid = ~r_owner_b;
        b_rsp_valid = r_owner_b;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Latch the winning op and its owner on grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner_b  <= 1'b0;
      r_op_we    <= 1'b0;
      r_op_addr1 <= '0;
      r_op_addr2 <= '0;
      r_op_wdata <= '0;
    end else if (w_grant) begin
      r_owner_b  <= w_grant_b;
      r_op_we    <= w_grant_b ? b_we    : a_we;
      r_op_addr1 <= w_grant_b ? b_addr1 : a_addr1;
      r_op_addr2 <= w_grant_b ? b_addr2 : a_addr2;
      r_op_wdata <= w_grant_b ? b_wdata : a_wdata;
    end
  end

  // Capture read data at the end of ACCESS; the bank writes on the same edge,
  // so a write op returns the pre-write contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_data1 <= '0;
      r_rsp_data2 <= '0;
      r_rsp_err   <= 1'b0;
    end else if (r_state == ST_ACCESS) begin
      r_rsp_data1 <= rb_out1;
      r_rsp_data2 <= rb_out2;
      r_rsp_err   <= w_addr0_drop;
    end
  end

  assign rsp_data1 = r_rsp_data1;
  assign rsp_data2 = r_rsp_data2;
  assign rsp_err   = r_rsp_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_regbank_arbiter.sv
// Bench for regbank_arbiter: a behavioural register bank, per-requester op
// queues driven over valid/ready, and a transaction-level reference model.
`timescale 1ns/1ps
module tb_regbank_arbiter;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int OP_W   = 1 + ADDR_W + ADDR_W + DATA_W;
  localparam int EXP_W  = 32 + 1 + 1 + DATA_W + DATA_W + 1 + ADDR_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              a_valid = 1'b0, a_we = 1'b0;
  logic [ADDR_W-1:0] a_addr1 = '0, a_addr2 = '0;
  logic [DATA_W-1:0] a_wdata = '0;
  logic              b_valid = 1'b0, b_we = 1'b0;
  logic [ADDR_W-1:0] b_addr1 = '0, b_addr2 = '0;
  logic [DATA_W-1:0] b_wdata = '0;
  logic              a_ready, a_rsp_valid, b_ready, b_rsp_valid;
  logic [DATA_W-1:0] rsp_data1, rsp_data2, rb_in, rb_out1, rb_out2;
  logic              rsp_err, rb_we;
  logic [ADDR_W-1:0] rb_add1, rb_add2;
  logic [1:0]        dbg_state;

  regbank_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_PROTECT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr1(a_addr1),
    .a_addr2(a_addr2), .a_wdata(a_wdata), .a_rsp_valid(a_rsp_valid),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr1(b_addr1),
    .b_addr2(b_addr2), .b_wdata(b_wdata), .b_rsp_valid(b_rsp_valid),
    .rsp_data1(rsp_data1), .rsp_data2(rsp_data2), .rsp_err(rsp_err),
    .rb_add1(rb_add1), .rb_add2(rb_add2), .rb_in(rb_in), .rb_we(rb_we),
    .rb_out1(rb_out1), .rb_out2(rb_out2), .dbg_state(dbg_state)
  );

  // ---------------- register bank (environment) ----------------
  logic [DATA_W-1:0] bank      [8];
  logic [DATA_W-1:0] init_vals [8];
  logic              bank_init = 1'b1;

  always @(posedge clk) begin
    if (bank_init) begin
      for (int i = 0; i < 8; i++) bank[i] <= init_vals[i];
    end else if (rb_we && rb_add1 != 3'd0) begin
      bank[rb_add1] <= rb_in;
    end
  end
  assign rb_out1 = (rb_add1 == 3'd0) ? 8'd13 : bank[rb_add1];
  assign rb_out2 = (rb_add2 == 3'd0) ? 8'd13 : bank[rb_add2];

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [DATA_W-1:0] model_mem [8];
  logic [EXP_W-1:0]  exp_q[$];
  logic [OP_W-1:0]   req_a[$];
  logic [OP_W-1:0]   req_b[$];
  int                cyc        = 0;
  int                last_grant = -100;
  logic              prefer_a   = 1'b1;
  logic [OP_W-1:0]   acc_vec    = '0;
  logic              a_acc = 1'b0, b_acc = 1'b0, gap_en = 1'b0;
  logic [7:0]        glog = '0;
  int                gcnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic monitor_step();
    logic              idle_exp, exp_ar, exp_br, owner_b, err, apply, we;
    logic [OP_W-1:0]   op;
    logic [EXP_W-1:0]  e;
    logic [31:0]       due;
    logic [DATA_W-1:0] d1, d2, wd;
    logic [ADDR_W-1:0] a1, a2;
    if (!rst_n) begin
      chk("reset_outputs", {a_ready, b_ready, a_rsp_valid, b_rsp_valid, rsp_data1, rsp_data2,
                            rsp_err, rb_add1, rb_add2, rb_in, rb_we, dbg_state}, '0);
      return;
    end
    // response due this cycle?
    due = 32'hFFFF_FFFF;
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      {due, owner_b, err, d1, d2, apply, a1, wd} = e;
    end
    if (exp_q.size() > 0 && due == 32'(cyc)) begin
      void'(exp_q.pop_front());
      chk("rsp_valid", {a_rsp_valid, b_rsp_valid}, {~owner_b, owner_b});
      chk("rsp_data", {rsp_err, rsp_data1, rsp_data2}, {err, d1, d2});
      if (apply) model_mem[a1] = wd;
    end else begin
      chk("rsp_quiet", {a_rsp_valid, b_rsp_valid}, 2'b00);
    end
    // bank pins: active only the cycle after a grant
    if (cyc == last_grant + 1) chk("bank_drive", {rb_we, rb_add1, rb_add2, rb_in}, acc_vec);
    else chk("bank_quiet", {rb_we, rb_add1, rb_add2, rb_in}, '0);
    // grant: at most one op per 3 cycles, winner by arbitration rule
    idle_exp = (cyc - last_grant) >= 3;
    exp_ar   = idle_exp && a_valid && (!b_valid || prefer_a);
    exp_br   = idle_exp && b_valid && !exp_ar;
    chk("ready", {a_ready, b_ready}, {exp_ar, exp_br});
    if (a_ready && a_valid) a_acc = 1'b1;
    if (b_ready && b_valid) b_acc = 1'b1;
    if (a_ready || b_ready) begin
      glog = {glog[6:0], b_ready};
      gcnt++;
    end
    if (exp_ar || exp_br) begin
      op = exp_ar ? {a_we, a_addr1, a_addr2, a_wdata} : {b_we, b_addr1, b_addr2, b_wdata};
      {we, a1, a2, wd} = op;
      d1    = model_mem[a1];
      d2    = model_mem[a2];
      err   = we && (a1 == 3'd0);
      apply = we && (a1 != 3'd0);
      exp_q.push_back({32'(cyc + 2), exp_br, err, d1, d2, apply, a1, wd});
      acc_vec    = {apply, a1, a2, wd};
      last_grant = cyc;
`ifdef ARB_RR_EN
      prefer_a = exp_br;
`endif
    end
  endtask

  initial forever begin
    @(negedge clk);
    monitor_step();
  end

  // ---------------- drivers ----------------
  task automatic drive_step();
    logic [OP_W-1:0] op;
    if (!rst_n) begin
      a_valid = 1'b0; b_valid = 1'b0; a_acc = 1'b0; b_acc = 1'b0;
      return;
    end
    if (a_acc) begin
      if (req_a.size() > 0) void'(req_a.pop_front());
      a_acc = 1'b0; a_valid = 1'b0;
    end
    if (b_acc) begin
      if (req_b.size() > 0) void'(req_b.pop_front());
      b_acc = 1'b0; b_valid = 1'b0;
    end
    if (!a_valid && req_a.size() > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
      op = req_a[0];
      {a_we, a_addr1, a_addr2, a_wdata} = op;
      a_valid = 1'b1;
    end
    if (!b_valid && req_b.size() > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
      op = req_b[0];
      {b_we, b_addr1, b_addr2, b_wdata} = op;
      b_valid = 1'b1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    drive_step();
  end

  task automatic push_op(input logic to_b, input logic we, input logic [ADDR_W-1:0] a1,
                         input logic [ADDR_W-1:0] a2, input logic [DATA_W-1:0] wd);
    if (to_b) req_b.push_back({we, a1, a2, wd});
    else req_a.push_back({we, a1, a2, wd});
  endtask

  task automatic push_rand(input logic to_b);
    push_op(to_b, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
  endtask

  task automatic drain(input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      #1;
      if (req_a.size() == 0 && req_b.size() == 0 && !a_valid && !b_valid && exp_q.size() == 0)
        done = 1'b1;
    end
    chk("drain_timeout", done, 1'b1);
  endtask

  task automatic model_reset();
    exp_q.delete();
    req_a.delete();
    req_b.delete();
    a_valid = 1'b0; b_valid = 1'b0; a_acc = 1'b0; b_acc = 1'b0;
    last_grant = -100;
    prefer_a   = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic got;
    for (int i = 0; i < 8; i++) init_vals[i] = 8'($urandom_range(0, 255));
    init_vals[0] = 8'd13;
    init_vals[3] = 8'h9E;
    init_vals[6] = 8'h42;
    for (int i = 0; i < 8; i++) model_mem[i] = init_vals[i];
    repeat (3) @(posedge clk);
    #1 bank_init = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;

    // write then read back, second port on r0
    push_op(1'b0, 1'b1, 3'd5, 3'd0, 8'hA7);
    push_op(1'b0, 1'b0, 3'd5, 3'd0, 8'h00);
    drain(100);
    chk("t2_rd1", rsp_data1, 8'hA7);
    chk("t2_rd2", rsp_data2, 8'd13);

    // write to r0 is dropped and flagged
    push_op(1'b1, 1'b1, 3'd0, 3'd0, 8'h55);
    drain(100);
    chk("t3_err", rsp_err, 1'b1);
    push_op(1'b1, 1'b0, 3'd0, 3'd0, 8'h00);
    drain(100);
    chk("t3_r0", {rsp_err, rsp_data1}, {1'b0, 8'd13});

    // simultaneous requests: grant order
    glog = '0;
    gcnt = 0;
    for (int i = 0; i < 4; i++) push_op(1'b0, 1'b0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 8'h00);
    for (int i = 0; i < 4; i++) push_op(1'b1, 1'b0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 8'h00);
    drain(200);
    chk("t4_count", gcnt, 8);
`ifdef ARB_RR_EN
    chk("t4_order", glog, 8'b0101_0101);
`else
    chk("t4_order", glog, 8'b0000_1111);
`endif

    // write returns pre-write contents, later read sees the new value
    push_op(1'b0, 1'b1, 3'd3, 3'd0, 8'h01);
    drain(100);
    chk("t5_prewrite", rsp_data1, init_vals[3]);
    push_op(1'b0, 1'b0, 3'd3, 3'd3, 8'h00);
    drain(100);
    chk("t5_newval", {rsp_data1, rsp_data2}, {8'h01, 8'h01});

    // reset in the middle of a write access
    push_op(1'b0, 1'b1, 3'd6, 3'd0, 8'h3C);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (a_ready) got = 1'b1;
    end
    chk("t1_grant_seen", got, 1'b1);
    @(posedge clk);
    #2;
    chk("t1_we_before", rb_we, 1'b1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t1_we_dropped", rb_we, 1'b0);
    chk("t1_no_rsp", {a_rsp_valid, b_rsp_valid}, 2'b00);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    push_op(1'b1, 1'b0, 3'd6, 3'd5, 8'h00);
    drain(100);
    chk("t1_aborted_write", {rsp_data1, rsp_data2}, {8'h42, 8'hA7});

    // randomized traffic with gaps
    gap_en = 1'b1;
    for (int it = 0; it < 25; it++) begin
      int na, nb;
      na = $urandom_range(0, 5);
      nb = $urandom_range(0, 5);
      for (int k = 0; k < na; k++) push_rand(1'b0);
      for (int k = 0; k < nb; k++) push_rand(1'b1);
      repeat ($urandom_range(0, 12)) @(posedge clk);
    end
    drain(5000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
